// File: rtl/enum_walk_pkg.sv
// Shared types for the family_t enumeration walker:
// member encoding, command codes, FSM states and the member table.
package enum_walk_pkg;

    typedef enum integer {
        father   = 0,
        mother   = 1,
        son0     = 2,
        son1     = 3,
        daughter = 4,
        gerbil   = 5,
        dog0     = 10,
        dog1     = 11,
        dog2     = 12,
        cat3     = 20,
        cat4     = 21,
        cat5     = 22,
        car3     = 30,
        car2     = 31,
        car1     = 32
    } family_t;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_FIRST = 3'd1,
        CMD_LAST  = 3'd2,
        CMD_NEXT  = 3'd3,
        CMD_PREV  = 3'd4
    } cmd_t;

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_t;

    localparam int NUM_MEMBERS = 15;
    localparam logic [3:0] LAST_IDX = 4'(NUM_MEMBERS - 1);

    // Ordinal to member value; out-of-range ordinals map to the first member.
    function automatic family_t member_at(input logic [3:0] idx);
        case (idx)
            4'd0:    return father;
            4'd1:    return mother;
            4'd2:    return son0;
            4'd3:    return son1;
            4'd4:    return daughter;
            4'd5:    return gerbil;
            4'd6:    return dog0;
            4'd7:    return dog1;
            4'd8:    return dog2;
            4'd9:    return cat3;
            4'd10:   return cat4;
            4'd11:   return cat5;
            4'd12:   return car3;
            4'd13:   return car2;
            4'd14:   return car1;
            default: return father;
        endcase
    endfunction

endpackage

// File: rtl/enum_walk_step.sv
// Combinational next-state for the enum register: command decode,
// wrap arithmetic and member lookup of the resulting ordinal.
module enum_walk_step
    import enum_walk_pkg::*;
(
    input  logic [3:0]  index,
    input  cmd_t        cmd,
    input  logic        valid,
    output logic [3:0]  index_nx,
    output logic        valid_nx,
    output logic        wrap,
    output logic        reject,
    output logic [31:0] value
);

    always_comb begin
        index_nx = index;
        valid_nx = valid;
        wrap     = 1'b0;
        reject   = 1'b0;
        case (cmd)
            CMD_NOP: begin
            end
            CMD_FIRST: begin
                index_nx = 4'd0;
                valid_nx = 1'b1;
            end
            CMD_LAST: begin
                index_nx = LAST_IDX;
                valid_nx = 1'b1;
            end
            CMD_NEXT: begin
                if (!valid) begin
                    reject = 1'b1;
                end else if (index >= LAST_IDX) begin
                    index_nx = 4'd0;
                    wrap     = 1'b1;
                end else begin
                    index_nx = index + 4'd1;
                end
            end
            CMD_PREV: begin
                if (!valid) begin
                    reject = 1'b1;
                end else if (index == 4'd0) begin
                    index_nx = LAST_IDX;
                    wrap     = 1'b1;
                end else begin
                    index_nx = index - 4'd1;
                end
            end
            default: reject = 1'b1;
        endcase
        // Rejected commands leave index_nx untouched, so value stays put.
        value = 32'(member_at(index_nx));
    end

endmodule

// File: rtl/enum_walk_arbiter.sv
// Two-requester round-robin sequencer for the family_t register:
// grant in S_IDLE, execute and acknowledge on leaving S_EXEC.
module enum_walk_arbiter
    import enum_walk_pkg::*;
#(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [2:0]        cmd0,
    input  logic [2:0]        cmd1,
    output logic [1:0]        ack,
    output logic              err,
    output logic [31:0]       value,
    output logic [3:0]        index,
    output logic              valid,
    output logic [WRAP_W-1:0] wraps
);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              rr_q, rr_d;
    cmd_t              cmd_q, cmd_d;
    logic [3:0]        index_q, index_d;
    logic              valid_q, valid_d;
    logic [31:0]       value_q, value_d;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [1:0]        ack_q, ack_d;
    logic              err_q, err_d;

    logic [3:0]  step_index;
    logic        step_valid;
    logic        step_wrap;
    logic        step_reject;
    logic [31:0] step_value;

    enum_walk_step u_step (
        .index    (index_q),
        .cmd      (cmd_q),
        .valid    (valid_q),
        .index_nx (step_index),
        .valid_nx (step_valid),
        .wrap     (step_wrap),
        .reject   (step_reject),
        .value    (step_value)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cmd_d   = cmd_q;
        index_d = index_q;
        valid_d = valid_q;
        value_d = value_q;
        wraps_d = wraps_q;
        ack_d   = 2'b00;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = (req == 2'b11) ? rr_q : req[1];
                    rr_d    = ~gnt_d;
                    cmd_d   = cmd_t'(gnt_d ? cmd1 : cmd0);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                index_d = step_index;
                valid_d = step_valid;
                value_d = step_value;
                if (step_wrap && !(&wraps_q)) begin
                    wraps_d = wraps_q + {{(WRAP_W-1){1'b0}}, 1'b1};
                end
                ack_d   = gnt_q ? 2'b10 : 2'b01;
                err_d   = step_reject;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            cmd_q   <= CMD_NOP;
            index_q <= 4'd0;
            valid_q <= 1'b0;
            value_q <= 32'd0;
            wraps_q <= '0;
            ack_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cmd_q   <= cmd_d;
            index_q <= index_d;
            valid_q <= valid_d;
            value_q <= value_d;
            wraps_q <= wraps_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign value = value_q;
    assign index = index_q;
    assign valid = valid_q;
    assign wraps = wraps_q;

endmodule

// File: tb/tb_enum_walk_arbiter.sv
// Scoreboard bench for enum_walk_arbiter: a request-level model queues
// expected acks, a negedge monitor compares them against the DUT.
module tb_enum_walk_arbiter;

    localparam int W       = 8;
    localparam int WMAX    = (1 << W) - 1;
    localparam int C_NOP   = 0;
    localparam int C_FIRST = 1;
    localparam int C_LAST  = 2;
    localparam int C_NEXT  = 3;
    localparam int C_PREV  = 4;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [2:0]   cmd0 = 3'd0;
    logic [2:0]   cmd1 = 3'd0;
    logic [1:0]   req;
    logic [1:0]   ack;
    logic         err;
    logic [31:0]  value;
    logic [3:0]   index;
    logic         valid;
    logic [W-1:0] wraps;

    assign req = {req1, req0};

    enum_walk_arbiter #(.WRAP_W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .cmd0  (cmd0),
        .cmd1  (cmd1),
        .ack   (ack),
        .err   (err),
        .value (value),
        .index (index),
        .valid (valid),
        .wraps (wraps)
    );

    always #5 clk = ~clk;

    int members[15] = '{0, 1, 2, 3, 4, 5, 10, 11, 12, 20, 21, 22, 30, 31, 32};

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [1:0] ack;
        logic       err;
        int         idx;
        logic       valid;
        int         wraps;
    } exp_t;

    exp_t expq[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Request-level model: a pending grant resolves one edge after it is taken.
    int m_idx = 0, m_wraps = 0, m_rr = 0, m_gid = 0, m_cmd = 0;
    bit m_valid = 0, m_busy = 0;

    always @(posedge clk or posedge rst) begin
        exp_t e;
        bit   rej;
        bit   wr;
        if (rst) begin
            m_idx = 0; m_valid = 0; m_wraps = 0; m_rr = 0; m_busy = 0;
            expq.delete();
        end else if (m_busy) begin
            check("req_held_during_exec", req[m_gid], 1);
            rej = 0;
            wr  = 0;
            case (m_cmd)
                C_NOP:   ;
                C_FIRST: begin m_idx = 0;  m_valid = 1; end
                C_LAST:  begin m_idx = 14; m_valid = 1; end
                C_NEXT:  if (!m_valid) rej = 1;
                         else begin wr = (m_idx == 14); m_idx = (m_idx + 1) % 15; end
                C_PREV:  if (!m_valid) rej = 1;
                         else begin wr = (m_idx == 0); m_idx = (m_idx + 14) % 15; end
                default: rej = 1;
            endcase
            if (wr && m_wraps < WMAX) m_wraps++;
            e.ack   = (m_gid == 1) ? 2'b10 : 2'b01;
            e.err   = rej;
            e.idx   = m_idx;
            e.valid = m_valid;
            e.wraps = m_wraps;
            expq.push_back(e);
            m_busy = 0;
        end else if (req != 2'b00) begin
            if (req == 2'b11) m_gid = m_rr;
            else              m_gid = req[1] ? 1 : 0;
            m_rr   = 1 - m_gid;
            m_cmd  = (m_gid == 1) ? int'(cmd1) : int'(cmd0);
            m_busy = 1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack != 2'b00) begin
                if (expq.size() == 0) begin
                    check("unexpected_ack", ack, 0);
                end else begin
                    e = expq.pop_front();
                    check("ack",   ack,   e.ack);
                    check("err",   err,   e.err);
                    check("value", value, members[e.idx]);
                    check("index", index, e.idx);
                    check("valid", valid, e.valid);
                    check("wraps", wraps, e.wraps);
                end
            end else if (err) begin
                check("err_without_ack", err, 0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the ack edge, req dropped.
    task automatic issue(input int id, input int c);
        bit got = 0;
        if (id == 0) begin cmd0 = 3'(c); req0 = 1'b1; end
        else         begin cmd1 = 3'(c); req1 = 1'b1; end
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            #1;
            if (ack[id]) got = 1;
        end
        if (!got) check("ack_timeout", 0, 1);
        if (id == 0) req0 = 1'b0;
        else         req1 = 1'b0;
    endtask

    task automatic rand_req(input int id, input int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            issue(id, $urandom_range(0, 7));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",   ack,   0);
        check("rst_err",   err,   0);
        check("rst_value", value, 0);
        check("rst_index", index, 0);
        check("rst_valid", valid, 0);
        check("rst_wraps", wraps, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(0, C_NEXT);
        check("uninit_next_valid", valid, 0);

        issue(0, C_FIRST);
        for (int i = 0; i < 14; i++) issue(0, C_NEXT);
        check("walk_end_value", value, 32);
        check("walk_end_index", index, 14);
        issue(0, C_NEXT);
        check("next_wrap_value", value, 0);
        check("next_wrap_wraps", wraps, 1);

        issue(1, C_LAST);
        check("last_value", value, 32);
        for (int i = 0; i < 3; i++) issue(1, C_PREV);
        check("prev3_value", value, 22);
        issue(1, C_FIRST);
        issue(1, C_PREV);
        check("prev_wrap_value", value, 32);
        check("prev_wrap_wraps", wraps, 2);

        for (int r = 0; r < 2; r++) begin
            fork
                issue(0, C_FIRST);
                issue(1, C_LAST);
            join
            check("contend_last_value", value, 32);
        end

        issue(0, 6);
        check("illegal_keeps_index", index, 14);

        issue(0, C_FIRST);
        for (int i = 0; i < 255; i++) issue(0, (i % 2 == 0) ? C_PREV : C_NEXT);
        check("sat_wraps", wraps, WMAX);
        issue(0, C_NEXT);
        check("sat_hold_wraps", wraps, WMAX);
        check("sat_index_wrapped", index, 0);

        fork
            rand_req(0, 80);
            rand_req(1, 80);
        join

        issue(0, C_LAST);
        repeat (2) @(posedge clk);
        #1;
        cmd0 = 3'(C_FIRST);
        req0 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ack",   ack,   0);
        check("abort_value", value, 0);
        check("abort_index", index, 0);
        check("abort_valid", valid, 0);
        check("abort_wraps", wraps, 0);
        req0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("no_ack_after_abort", ack, 0);
        end

        repeat (4) @(posedge clk);
        check("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
